// File: rtl/rv32_rom_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot ROM loader.
// The master drives the serial receiver side; the slave is the loader itself.
interface rv32_rom_loader_if #(
    parameter int unsigned ADDR_WIDTH = 12
);
    logic                  Start;
    logic [7:0]            RxData;
    logic                  RxValid;
    logic [ADDR_WIDTH-1:0] Address;
    logic [31:0]           Data;
    logic                  WriteEnable;
    logic                  Busy;
    logic                  Done;
    logic                  Error;

    modport master (
        output Start, RxData, RxValid,
        input  Address, Data, WriteEnable, Busy, Done, Error
    );

    modport slave (
        input  Start, RxData, RxValid,
        output Address, Data, WriteEnable, Busy, Done, Error
    );
endinterface

// File: rtl/rv32_rom_loader.sv
// Serial boot loader: parses a length-prefixed, XOR-checksummed byte image
// and writes it word by word into instruction memory while holding the CPU in reset.
module rv32_rom_loader #(
    parameter int unsigned ADDR_WIDTH = 12
) (
    input logic             Clock,
    input logic             Reset,
    rv32_rom_loader_if.slave bus
);
    // Largest legal word count; clamped so the compare stays within 32 bits.
    localparam int unsigned Capacity = (ADDR_WIDTH >= 16) ? 32'h0001_0000 : (32'd1 << ADDR_WIDTH);

    typedef enum logic [2:0] {
        StIdle,
        StLenLo,
        StLenHi,
        StData,
        StCheck
    } state_e;

    state_e                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [1:0]            idx_q, idx_d;
    logic [7:0]            csum_q, csum_d;
    logic [31:0]           word_q, word_d;
    logic [31:0]           data_q, data_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [15:0]           len_full;

    assign len_full = {bus.RxData, len_q[7:0]};

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        word_d  = word_q;
        data_d  = data_q;
        addr_d  = addr_q;
        we_d    = 1'b0;
        done_d  = done_q;
        error_d = error_q;

        // Address advances exactly once, in the cycle after each write strobe.
        if (we_q) begin
            addr_d = addr_q + 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (bus.Start) begin
                    state_d = StLenLo;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    csum_d  = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    addr_d  = '0;
                end
            end
            StLenLo: begin
                if (bus.RxValid) begin
                    len_d[7:0] = bus.RxData;
                    state_d    = StLenHi;
                end
            end
            StLenHi: begin
                if (bus.RxValid) begin
                    len_d[15:8] = bus.RxData;
                    if (len_full == 16'd0) begin
                        state_d = StCheck;
                    end else if ({16'd0, len_full} > Capacity) begin
                        state_d = StIdle;
                        error_d = 1'b1;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (bus.RxValid) begin
                    word_d[{idx_q, 3'b000} +: 8] = bus.RxData;
                    csum_d = csum_q ^ bus.RxData;
                    idx_d  = idx_q + 1'b1;
                    if (idx_q == 2'd3) begin
                        data_d = word_d;
                        we_d   = 1'b1;
                        cnt_d  = cnt_q + 16'd1;
                        // Leave for CHECK alongside the last write so a
                        // back-to-back checksum byte is not missed.
                        if ((cnt_q + 16'd1) == len_q) begin
                            state_d = StCheck;
                        end
                    end
                end
            end
            StCheck: begin
                if (bus.RxValid) begin
                    if (bus.RxData == csum_q) begin
                        done_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= StIdle;
            len_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            csum_q  <= '0;
            word_q  <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            word_q  <= word_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign bus.Address     = addr_q;
    assign bus.Data        = data_q;
    assign bus.WriteEnable = we_q;
    assign bus.Busy        = busy_q;
    assign bus.Done        = done_q;
    assign bus.Error       = error_q;
endmodule
